// File: rtl/shift_pkg.sv
// Shared types and elaboration helpers for the pipelined barrel shifter.
// The mode encoding is visible at the block's ports, so producers and the
// shifter agree on it through this package.
package shift_pkg;

    // Shift operations understood by the execute-stage shifter.
    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROR = 2'd3
    } shift_mode_t;

    // First mux level owned by pipeline stage k when LEVELS levels are spread
    // over STAGES stages. Stage k owns [level_lo(k), level_lo(k+1)-1], which is
    // never empty as long as STAGES <= LEVELS.
    function automatic int level_lo(input int k, input int levels, input int stages);
        return (k * levels) / stages;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One level of the logarithmic shifter: a fixed left shift or left rotate by
// DIST bits, or a straight pass-through when the level is not enabled.
// Right shifts are handled by the top module bit-reversing the operand, so
// this level only ever moves bits towards the MSB.
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             enable_i,
    input  shift_mode_t      mode_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    // Rotate wraps the top DIST bits round to the bottom; every other mode
    // back-fills the vacated LSBs with the pipelined fill bit.
    always_comb begin
        data_o = data_i;
        if (enable_i) begin
            if (mode_i == ROR) begin
                data_o = {data_i[WIDTH-DIST-1:0], data_i[WIDTH-1:WIDTH-DIST]};
            end else begin
                data_o = {data_i[WIDTH-DIST-1:0], {DIST{fill_i}}};
            end
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter for the execute stage.
// The shift amount is decomposed into LEVELS = log2(WIDTH) power-of-two mux
// levels, spread as evenly as possible over STAGES register stages. Right
// shifts and rotates are done as left operations on the bit-reversed operand,
// with the result reversed back at the output. A valid/ready handshake with a
// per-stage ready chain lets bubbles collapse and stalls hold their contents.
module pipelined_barrel_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [WIDTH-1:0]         In,
    input  logic [$clog2(WIDTH)-1:0] Amount,
    input  logic [1:0]               Mode,
    input  logic [TAG_W-1:0]         InTag,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [WIDTH-1:0]         Out,
    output logic [TAG_W-1:0]         OutTag
);

    localparam int SHW    = $clog2(WIDTH);
    localparam int LEVELS = SHW;

    // Reject configurations the level split cannot handle.
    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_badWidth
        $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 8");
    end
    if (STAGES < 1 || STAGES > LEVELS) begin : g_badStages
        $error("pipelined_barrel_shifter: STAGES must be in 1..log2(WIDTH)");
    end

    // Mirror a word end-for-end so right shifts become left shifts.
    function automatic logic [WIDTH-1:0] reverseBits(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Index k of these arrays is what stage k consumes; index STAGES of the
    // data/mode/tag/valid arrays is the output register of the last stage.
    logic [WIDTH-1:0] stageData  [STAGES+1];
    shift_mode_t      stageMode  [STAGES+1];
    logic [TAG_W-1:0] stageTag   [STAGES+1];
    logic             stageValid [STAGES+1];
    logic [SHW-1:0]   stageAmt   [STAGES];
    logic             stageFill  [STAGES];
    logic [STAGES:0]  rdy;

    shift_mode_t modeIn;

    assign modeIn        = shift_mode_t'(Mode);
    assign stageData[0]  = (modeIn == SLL) ? In : reverseBits(In);
    assign stageMode[0]  = modeIn;
    assign stageTag[0]   = InTag;
    assign stageValid[0] = InValid;
    assign stageAmt[0]   = Amount;
    assign stageFill[0]  = (modeIn == SRA) && In[WIDTH-1];

    // Ready ripples back from the consumer: a stage can take new contents when
    // it is empty or when its own contents are leaving this cycle.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = OutReady;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !stageValid[k+1] || rdy[k+1];
        end
    end

    assign InReady = nReset && rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = level_lo(k, LEVELS, STAGES);
        localparam int HI  = level_lo(k + 1, LEVELS, STAGES);
        localparam int NLV = HI - LO;

        logic [WIDTH-1:0] levelData [NLV+1];

        logic [WIDTH-1:0] data_q,  data_d;
        shift_mode_t      mode_q,  mode_d;
        logic [TAG_W-1:0] tag_q,   tag_d;
        logic             valid_q, valid_d;

        assign levelData[0] = stageData[k];

        for (genvar j = 0; j < NLV; j++) begin : g_level
            shift_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << (LO + j))
            ) u_level (
                .data_i   (levelData[j]),
                .enable_i (stageAmt[k][LO+j]),
                .mode_i   (stageMode[k]),
                .fill_i   (stageFill[k]),
                .data_o   (levelData[j+1])
            );
        end

        // Take upstream contents when ready; an empty upstream leaves a bubble,
        // and a stalled stage keeps everything it holds.
        always_comb begin
            data_d  = data_q;
            mode_d  = mode_q;
            tag_d   = tag_q;
            valid_d = valid_q;
            if (rdy[k]) begin
                valid_d = stageValid[k];
                if (stageValid[k]) begin
                    data_d = levelData[NLV];
                    mode_d = stageMode[k];
                    tag_d  = stageTag[k];
                end
            end
        end

        // Stage register; reset empties the pipe and zeroes what it shows.
        always_ff @(posedge Clock) begin
            if (!nReset) begin
                data_q  <= '0;
                mode_q  <= SLL;
                tag_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                mode_q  <= mode_d;
                tag_q   <= tag_d;
                valid_q <= valid_d;
            end
        end

        assign stageData[k+1]  = data_q;
        assign stageMode[k+1]  = mode_q;
        assign stageTag[k+1]   = tag_q;
        assign stageValid[k+1] = valid_q;

        // Only stages with a successor need to carry the amount and fill bit.
        if (k < STAGES - 1) begin : g_carry
            logic [SHW-1:0] amt_q,  amt_d;
            logic           fill_q, fill_d;

            // Amount and fill travel alongside the data they belong to.
            always_comb begin
                amt_d  = amt_q;
                fill_d = fill_q;
                if (rdy[k] && stageValid[k]) begin
                    amt_d  = stageAmt[k];
                    fill_d = stageFill[k];
                end
            end

            // Carry register for the not-yet-applied shift controls.
            always_ff @(posedge Clock) begin
                if (!nReset) begin
                    amt_q  <= '0;
                    fill_q <= 1'b0;
                end else begin
                    amt_q  <= amt_d;
                    fill_q <= fill_d;
                end
            end

            assign stageAmt[k+1]  = amt_q;
            assign stageFill[k+1] = fill_q;
        end
    end

    assign OutValid = stageValid[STAGES];
    assign OutTag   = stageTag[STAGES];
    assign Out      = (stageMode[STAGES] == SLL) ? stageData[STAGES]
                                                 : reverseBits(stageData[STAGES]);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter.
// A five-stage instance is driven through a scoreboard fed from an arithmetic
// reference model; a single-stage instance covers the one-cycle latency case.
module tb_pipelined_barrel_shifter;

    localparam int DEEP  = 5;
    localparam int NRAND = 10000;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic nReset;

    logic        inValid, inReady, outValid, outReady;
    logic [31:0] inData, outData;
    logic [4:0]  amount, inTag, outTag;
    logic [1:0]  mode;

    logic        s1InValid, s1InReady, s1OutValid, s1OutReady;
    logic [31:0] s1In, s1Out;
    logic [4:0]  s1Amount, s1InTag, s1OutTag;
    logic [1:0]  s1Mode;

    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;
    int   outCount = 0;
    int   firstInCycle = 0;
    int   firstOutCycle = 0;
    logic captureFirstIn = 1'b0;
    logic captureFirstOut = 1'b0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    pipelined_barrel_shifter #(.WIDTH(32), .STAGES(DEEP), .TAG_W(5)) dut (
        .Clock    (clk),
        .nReset   (nReset),
        .InValid  (inValid),
        .InReady  (inReady),
        .In       (inData),
        .Amount   (amount),
        .Mode     (mode),
        .InTag    (inTag),
        .OutValid (outValid),
        .OutReady (outReady),
        .Out      (outData),
        .OutTag   (outTag)
    );

    pipelined_barrel_shifter #(.WIDTH(32), .STAGES(1), .TAG_W(5)) dutS1 (
        .Clock    (clk),
        .nReset   (nReset),
        .InValid  (s1InValid),
        .InReady  (s1InReady),
        .In       (s1In),
        .Amount   (s1Amount),
        .Mode     (s1Mode),
        .InTag    (s1InTag),
        .OutValid (s1OutValid),
        .OutReady (s1OutReady),
        .Out      (s1Out),
        .OutTag   (s1OutTag)
    );

    // Reference model: the shift rules written with plain operators.
    function automatic logic [31:0] refShift(input logic [31:0] v, input int amt, input int m);
        logic [31:0] r;
        case (m)
            0:       r = v << amt;
            1:       r = v >> amt;
            2:       r = 32'($signed(v) >>> amt);
            default: r = (v >> amt) | (v << (32 - amt));
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Present one request and hold it until the shifter takes it.
    task automatic applyStimulus(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m, input logic [4:0] t);
        int waited = 0;
        inValid = 1'b1;
        inData  = d;
        amount  = a;
        mode    = m;
        inTag   = t;
        @(negedge clk);
        while (!inReady && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!inReady) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept-timeout: request tag %0d never accepted", t);
        end
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for every expected result to come out.
    task automatic waitDrain(input string name);
        int waited = 0;
        while (expQ.size() != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        checkOutput(name, 32'(expQ.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Input side of the scoreboard: each accepted request queues its answer.
    always @(negedge clk) begin
        if (nReset && inValid && inReady) begin
            expQ.push_back('{data: refShift(inData, int'(amount), int'(mode)), tag: inTag});
            if (captureFirstIn) begin
                firstInCycle   = cycle;
                captureFirstIn = 1'b0;
            end
        end
    end

    // Output side: whatever is presented must be the oldest outstanding answer,
    // and it is retired only when the consumer takes it.
    always @(negedge clk) begin
        if (nReset && outValid) begin
            if (captureFirstOut) begin
                firstOutCycle   = cycle;
                captureFirstOut = 1'b0;
            end
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected-result: got %h tag %0d, expected none", outData, outTag);
            end else begin
                checkOutput("result-data", outData, expQ[0].data);
                checkOutput("result-tag", 32'(outTag), 32'(expQ[0].tag));
                if (outReady) void'(expQ.pop_front());
            end
            if (outReady) outCount++;
        end
    end

    initial begin
        #5_000_000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepted;
        int sent;
        int guard;
        int ghostBase;
        logic pending;

        nReset = 1'b0;
        inValid = 1'b0; outReady = 1'b0; inData = '0; amount = '0; mode = '0; inTag = '0;
        s1InValid = 1'b0; s1OutReady = 1'b1; s1In = '0; s1Amount = '0; s1Mode = '0; s1InTag = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset-outvalid", 32'(outValid), 32'd0);
        checkOutput("reset-out", outData, 32'd0);
        checkOutput("reset-outtag", 32'(outTag), 32'd0);
        checkOutput("reset-inready", 32'(inReady), 32'd0);
        checkOutput("reset-s1-outvalid", 32'(s1OutValid), 32'd0);
        @(posedge clk);
        #1;
        nReset = 1'b1;
        $display("[TB] reset released");

        // Single-stage instance: result one cycle after the transfer.
        s1InValid = 1'b1; s1In = 32'h8000_0001; s1Amount = 5'd4; s1Mode = 2'd0; s1InTag = 5'h15;
        @(negedge clk);
        checkOutput("s1-inready", 32'(s1InReady), 32'd1);
        checkOutput("s1-early-valid", 32'(s1OutValid), 32'd0);
        @(posedge clk);
        #1;
        s1InValid = 1'b0;
        @(negedge clk);
        checkOutput("s1-outvalid", 32'(s1OutValid), 32'd1);
        checkOutput("s1-out", s1Out, 32'h0000_0010);
        checkOutput("s1-outtag", 32'(s1OutTag), 32'h15);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("s1-drained", 32'(s1OutValid), 32'd0);
        @(posedge clk);
        #1;

        // Boundary vectors through the deep instance.
        outReady = 1'b1;
        applyStimulus(32'h8000_0001, 5'd4,  2'd0, 5'd1);
        applyStimulus(32'h8000_0000, 5'd31, 2'd2, 5'd2);
        applyStimulus(32'h8000_0000, 5'd31, 2'd1, 5'd3);
        applyStimulus(32'h0000_0001, 5'd1,  2'd3, 5'd4);
        applyStimulus(32'h8000_0000, 5'd31, 2'd0, 5'd5);
        applyStimulus(32'h0000_0001, 5'd31, 2'd3, 5'd6);
        for (int m = 0; m < 4; m++) applyStimulus(32'hDEAD_BEEF, 5'd0, 2'(m), 5'(8 + m));
        inValid = 1'b0;
        waitDrain("vectors-drained");

        // Ten back-to-back requests; first result exactly DEEP cycles later.
        captureFirstIn  = 1'b1;
        captureFirstOut = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(i));
        inValid = 1'b0;
        waitDrain("stream-drained");
        checkOutput("stream-latency", 32'(firstOutCycle - firstInCycle), 32'(DEEP));

        // Back-pressure: a blocked consumer fills exactly DEEP slots.
        outReady = 1'b0;
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            inValid = 1'b1;
            inData  = $urandom;
            amount  = 5'($urandom_range(0, 31));
            mode    = 2'($urandom_range(0, 3));
            inTag   = 5'(16 + i);
            @(negedge clk);
            if (!inReady) break;
            accepted++;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        checkOutput("bp-accepted", 32'(accepted), 32'(DEEP));
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("bp-outvalid", 32'(outValid), 32'd1);
        checkOutput("bp-inready", 32'(inReady), 32'd0);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        waitDrain("bp-drained");

        // Random handshakes on both sides.
        sent = 0;
        guard = 0;
        pending = 1'b0;
        while (sent < NRAND && guard < 60000) begin
            guard++;
            outReady = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 3) != 0) begin
                pending = 1'b1;
                inData  = $urandom;
                case ($urandom_range(0, 9))
                    0:       amount = 5'd0;
                    1:       amount = 5'd31;
                    default: amount = 5'($urandom_range(0, 31));
                endcase
                mode  = 2'($urandom_range(0, 3));
                inTag = 5'($urandom);
            end
            inValid = pending;
            @(negedge clk);
            if (pending && inReady) begin
                pending = 1'b0;
                sent++;
            end
            @(posedge clk);
            #1;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        checkOutput("random-sent", 32'(sent), 32'(NRAND));
        waitDrain("random-drained");

        // Reset with three requests in flight discards them all.
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 5'(24 + i));
        nReset   = 1'b0;
        inValid  = 1'b1;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("rst-inready-low", 32'(inReady), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rst-outvalid", 32'(outValid), 32'd0);
        checkOutput("rst-out", outData, 32'd0);
        expQ.delete();
        @(posedge clk);
        #1;
        nReset    = 1'b1;
        inValid   = 1'b0;
        ghostBase = outCount;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("rst-no-ghost", 32'(outCount - ghostBase), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
